timing_loop_filter: RTL

TIMING_LOOP_FILTER -- requirements
Module: timing_loop_filter

---
 rtl/timing_loop_filter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/timing_loop_filter.sv
// Proportional-integral loop filter for symbol timing recovery, with a
// two-state lock detector that switches the loop gains between ACQ and TRACK.
module timing_loop_filter #(
    parameter int ERR_W      = 16,
    parameter int CTRL_W     = 18,
    parameter int KP_ACQ_SH  = 2,
    parameter int KI_ACQ_SH  = 8,
    parameter int KP_TRK_SH  = 4,
    parameter int KI_TRK_SH  = 12,
    parameter int INT_LIM    = 131071,
    parameter int LOCK_THR   = 256,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_THR = 1024,
    parameter int UNLOCK_CNT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [ERR_W-1:0]  err_i,
    input  logic                     err_valid_i,
    input  logic                     freeze_i,
    output logic signed [CTRL_W-1:0] ctrl_o,
    output logic                     ctrl_valid_o,
    output logic                     locked_o
);

    localparam int ACC_W   = CTRL_W + 17;
    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic signed [ACC_W:0] LIM_HI  = (ACC_W+1)'(longint'(INT_LIM) <<< 16);
    localparam logic signed [ACC_W:0] LIM_LO  = -LIM_HI;
    localparam logic signed [ACC_W:0] CTRL_HI = (ACC_W+1)'((longint'(1) <<< (CTRL_W-1)) - 1);
    localparam logic signed [ACC_W:0] CTRL_LO = -CTRL_HI - (ACC_W+1)'(1);

    typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

    function automatic logic signed [ACC_W-1:0] clamp_integ(input logic signed [ACC_W:0] x);
        logic signed [ACC_W:0] y;
        if (x > LIM_HI)      y = LIM_HI;
        else if (x < LIM_LO) y = LIM_LO;
        else                 y = x;
        return y[ACC_W-1:0];
    endfunction

    function automatic logic signed [CTRL_W-1:0] sat_ctrl(input logic signed [ACC_W:0] x);
        logic signed [ACC_W:0] s;
        s = x >>> 16;
        if (s > CTRL_HI)      s = CTRL_HI;
        else if (s < CTRL_LO) s = CTRL_LO;
        return s[CTRL_W-1:0];
    endfunction

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt, cnt_next, cnt_inc;
    logic                     accept;
    logic signed [ERR_W:0]    err_ext;
    logic [ERR_W:0]           err_abs;
    logic                     err_small, err_big;
    int                       kp_sh, ki_sh;
    logic signed [ACC_W-1:0]  e, prop, inc, integ, integ_new;
    logic signed [ACC_W:0]    integ_sum, sum_p1;
    logic signed [ACC_W-1:0]  prop_p0, integ_p0;
    logic                     vld_p0;

    assign accept = err_valid_i & ~freeze_i;

    always_comb begin
        err_ext   = (ERR_W+1)'(err_i);
        err_abs   = err_ext[ERR_W] ? unsigned'(-err_ext) : unsigned'(err_ext);
        err_small = err_abs <  (ERR_W+1)'(LOCK_THR);
        err_big   = err_abs >= (ERR_W+1)'(UNLOCK_THR);
        kp_sh     = (state == TRACK) ? KP_TRK_SH : KP_ACQ_SH;
        ki_sh     = (state == TRACK) ? KI_TRK_SH : KI_ACQ_SH;
        e         = ACC_W'(err_i) <<< 16;
        prop      = e >>> kp_sh;
        inc       = e >>> ki_sh;
        integ_sum = (ACC_W+1)'(integ) + (ACC_W+1)'(inc);
        integ_new = clamp_integ(integ_sum);
        sum_p1    = (ACC_W+1)'(integ_p0) + (ACC_W+1)'(prop_p0);
    end

    // Stage p0: integrator update and proportional term capture
    always_ff @(posedge clk) begin
        if (reset) begin
            integ  <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            if (accept) integ <= integ_new;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            prop_p0  <= prop;
            integ_p0 <= integ_new;
        end
    end

    // Stage p1: sum, scale to ctrl LSB and saturate; ctrl_o holds between updates
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_o       <= '0;
            ctrl_valid_o <= 1'b0;
        end else begin
            ctrl_valid_o <= vld_p0;
            if (vld_p0) ctrl_o <= sat_ctrl(sum_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACQ;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cnt_inc    = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
        if (accept) begin
            case (state)
                ACQ: begin
                    if (!err_small)                        cnt_next = '0;
                    else if (cnt_inc == CNT_W'(LOCK_CNT)) begin
                        state_next = TRACK;
                        cnt_next   = '0;
                    end else                               cnt_next = cnt_inc;
                end
                TRACK: begin
                    if (!err_big)                            cnt_next = '0;
                    else if (cnt_inc == CNT_W'(UNLOCK_CNT)) begin
                        state_next = ACQ;
                        cnt_next   = '0;
                    end else                                 cnt_next = cnt_inc;
                end
                default: begin
                    state_next = ACQ;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked_o = (state == TRACK);
    end

endmodule
